// File: rtl/fp_axis_stream_tester_if.sv
// Handshake bundle between the FP stream tester and the FP IP core under test.
//   s_axis_a_*       operand A stream (tester -> IP)
//   s_axis_b_*       operand B stream (tester -> IP)
//   m_axis_result_*  result stream    (IP -> tester)
// Modports: master = tester side, slave = IP side.
interface fp_axis_stream_tester_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] s_axis_a_tdata;
  logic              s_axis_a_tvalid;
  logic              s_axis_a_tready;
  logic [DATA_W-1:0] s_axis_b_tdata;
  logic              s_axis_b_tvalid;
  logic              s_axis_b_tready;
  logic [DATA_W-1:0] m_axis_result_tdata;
  logic              m_axis_result_tvalid;
  logic              m_axis_result_tready;

  modport master (
    output s_axis_a_tdata, s_axis_a_tvalid,
    input  s_axis_a_tready,
    output s_axis_b_tdata, s_axis_b_tvalid,
    input  s_axis_b_tready,
    input  m_axis_result_tdata, m_axis_result_tvalid,
    output m_axis_result_tready
  );

  modport slave (
    input  s_axis_a_tdata, s_axis_a_tvalid,
    output s_axis_a_tready,
    input  s_axis_b_tdata, s_axis_b_tvalid,
    output s_axis_b_tready,
    output m_axis_result_tdata, m_axis_result_tvalid,
    input  m_axis_result_tready
  );
endinterface

// File: rtl/fp_axis_stream_tester.sv
// AXI-Stream stimulus/checker for two-operand FP IP cores.
// Issues (A,B) pairs from a writable vector RAM with up to MAX_OUTST results in flight, drives
// A and B with independent handshakes and compares each returned result with the stored
// expected value.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start                pulse, begins a run from IDLE or DONE
//   cfg_num_vec          vectors in the run (sampled on start, clamped to DEPTH)
//   vec_we/vec_addr      vector RAM write port (ignored while busy)
//   vec_a/vec_b/vec_exp  operand A, operand B, expected result
//   axis                 A, B and result streams (master modport)
//   busy/done/pass       run status; pass valid when done
//   err_count            mismatches this run (saturating)
//   first_err_idx        index of first mismatch
//   timed_out            run ended because no result arrived in time
module fp_axis_stream_tester #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned STALL_PER = 0,
  parameter int unsigned TIMEOUT   = 1024,
  parameter bit          NAN_AWARE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   cfg_num_vec,
  input  logic                     vec_we,
  input  logic [$clog2(DEPTH)-1:0] vec_addr,
  input  logic [DATA_W-1:0]        vec_a,
  input  logic [DATA_W-1:0]        vec_b,
  input  logic [DATA_W-1:0]        vec_exp,
  fp_axis_stream_tester_if.master  axis,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH):0]   err_count,
  output logic [$clog2(DEPTH)-1:0] first_err_idx,
  output logic                     timed_out
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned OW        = $clog2(MAX_OUTST + 1);
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam int unsigned SW        = (STALL_PER > 1) ? $clog2(STALL_PER) : 1;
  localparam int unsigned StallLast = (STALL_PER == 0) ? 0 : STALL_PER - 1;
  localparam int unsigned ExpW      = (DATA_W == 64) ? 11 : (DATA_W == 16) ? 5 : 8;
  localparam int unsigned MantW     = DATA_W - 1 - ExpW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Vector RAM, deliberately not reset.
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] mem_e [DEPTH];

  state_e            state_q, state_d;
  logic [AW:0]       num_q, num_d;
  logic [AW:0]       issue_q, issue_d;
  logic [AW:0]       res_q, res_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic [AW:0]       err_q, err_d;
  logic [AW-1:0]     first_q, first_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]     stall_q, stall_d;

  logic              busy_w;
  logic              r_ready;
  logic              a_hs, b_hs, r_hs;
  logic              pair_done;
  logic              res_counted;
  logic              res_match;
  logic [DATA_W-1:0] exp_w;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (&x[DATA_W-2 -: ExpW]) && (|x[MantW-1:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (vec_we && !busy_w) begin
      mem_a[vec_addr] <= vec_a;
      mem_b[vec_addr] <= vec_b;
      mem_e[vec_addr] <= vec_exp;
    end
  end

  assign busy_w  = (state_q == StRun) || (state_q == StDrain);
  // Stall slot is the last count of each STALL_PER-cycle window, only while a run is active.
  assign r_ready = !(busy_w && (STALL_PER != 0) && (stall_q == SW'(StallLast)));

  assign a_hs = a_valid_q && axis.s_axis_a_tready;
  assign b_hs = b_valid_q && axis.s_axis_b_tready;
  assign r_hs = axis.m_axis_result_tvalid && r_ready;

  // A pair completes on the cycle its last still-pending channel handshakes.
  assign pair_done = (a_valid_q || b_valid_q) && (!a_valid_q || a_hs) && (!b_valid_q || b_hs);

  assign res_counted = r_hs && (outst_q != '0);
  assign exp_w       = mem_e[res_q[AW-1:0]];
  assign res_match   = (axis.m_axis_result_tdata == exp_w) ||
                       (NAN_AWARE && is_nan(axis.m_axis_result_tdata) && is_nan(exp_w));

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issue_d    = issue_q;
    res_d      = res_q;
    outst_d    = outst_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    err_d      = err_q;
    first_d    = first_q;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
    stall_d    = stall_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_d      = (cfg_num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num_vec;
          issue_d    = '0;
          res_d      = '0;
          outst_d    = '0;
          err_d      = '0;
          first_d    = '0;
          tmo_flag_d = 1'b0;
          tmo_cnt_d  = '0;
          stall_d    = '0;
          a_valid_d  = 1'b0;
          b_valid_d  = 1'b0;
          state_d    = (cfg_num_vec == '0) ? StDone : StRun;
        end
      end

      StRun, StDrain: begin
        if (STALL_PER != 0) begin
          stall_d = (stall_q == SW'(StallLast)) ? '0 : stall_q + SW'(1);
        end

        if (a_hs) a_valid_d = 1'b0;
        if (b_hs) b_valid_d = 1'b0;
        if (pair_done) issue_d = issue_q + (AW+1)'(1);

        outst_d = outst_q + OW'(pair_done) - OW'(res_counted);

        if (r_hs) begin
          // Spurious results (nothing outstanding) always count as errors.
          if (!res_counted || !res_match) begin
            if (err_q != '1) err_d = err_q + (AW+1)'(1);
            if (err_q == '0) first_d = res_q[AW-1:0];
          end
          if (res_counted) res_d = res_q + (AW+1)'(1);
        end

        if (r_hs) begin
          tmo_cnt_d = '0;
        end else if (outst_q != '0) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end

        // Issue decision uses post-completion counts so pairs can go back-to-back.
        if ((state_q == StRun) && !a_valid_d && !b_valid_d && (issue_d < num_q) &&
            (outst_d < OW'(MAX_OUTST))) begin
          a_valid_d = 1'b1;
          b_valid_d = 1'b1;
          a_data_d  = mem_a[issue_d[AW-1:0]];
          b_data_d  = mem_b[issue_d[AW-1:0]];
        end

        if ((issue_d == num_q) && !a_valid_d && !b_valid_d) begin
          state_d = (outst_d == '0) ? StDone : StDrain;
        end

        if (!r_hs && (outst_q != '0) && (tmo_cnt_q == TW'(TIMEOUT - 1))) begin
          state_d    = StDone;
          tmo_flag_d = 1'b1;
          a_valid_d  = 1'b0;
          b_valid_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      num_q      <= '0;
      issue_q    <= '0;
      res_q      <= '0;
      outst_q    <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      err_q      <= '0;
      first_q    <= '0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issue_q    <= issue_d;
      res_q      <= res_d;
      outst_q    <= outst_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      err_q      <= err_d;
      first_q    <= first_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign axis.s_axis_a_tdata       = a_data_q;
  assign axis.s_axis_a_tvalid      = a_valid_q;
  assign axis.s_axis_b_tdata       = b_data_q;
  assign axis.s_axis_b_tvalid      = b_valid_q;
  assign axis.m_axis_result_tready = r_ready;

  assign busy          = busy_w;
  assign done          = (state_q == StDone);
  assign pass          = (state_q == StDone) && (err_q == '0) && !tmo_flag_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign timed_out     = tmo_flag_q;

endmodule
